approx_mult_pipe: RTL

Parametrised, pipelined unsigned approximate multiplier with runtime exact/approximate mode, valid/ready handshake and an on-line error-event counter. It generalises the fixed 8x8, six-approximated-row combinational multiplier to arbitrary operand width and approximated row count. It registers results across a configurable number of stages, with full backpressure support. It sits in the accelerator datapath between operand FIFOs and the accumulator, and lets software measure how often approximation actually changes a result.

---
 rtl/approx_mult_pkg.sv | 43 ++++
 rtl/approx_mult_pipe_if.sv | 34 +++
 rtl/approx_pp_compress.sv | 47 ++++
 rtl/approx_mult_pipe.sv | 107 ++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// rtl/approx_mult_pkg.sv - shared constants, mode type and approximate-product helper
//
// Purpose : default parameters for approx_mult_pipe, the operand-mode enum and
//           approx_prod(), a width-generic model of the approximate product
//           (operands zero-extended into MAX_W bits).
// Contents: DEF_* defaults, DEF_PROD_W, MAX_W, mode_e, approx_prod().
package approx_mult_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_APPROX_ROWS = 6;
    localparam int DEF_STAGES      = 2;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_PROD_W      = 2 * DEF_WIDTH;

    // Widest operand approx_prod() can model.
    localparam int MAX_W = 32;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mode_e;

    // Rows at or above l are exact; each row pair (2k, 2k+1) below l is OR-merged
    // column by column, keeping only columns of weight >= l.
    function automatic logic [2*MAX_W-1:0] approx_prod(input logic [MAX_W-1:0] x,
                                                        input logic [MAX_W-1:0] y,
                                                        input int               l);
        logic [2*MAX_W-1:0] acc;
        logic [2*MAX_W-1:0] y_ext;
        logic [2*MAX_W-1:0] hi_mask;
        y_ext   = {{MAX_W{1'b0}}, y};
        hi_mask = ~((64'(1) << l) - 64'(1));
        acc     = (64'(x >> l) * y_ext) << l;
        for (int k = 0; k < MAX_W / 2; k++) begin
            if (2 * k < l) begin
                acc = acc + ((((y_ext << (2 * k))     & {64{1'(x >> (2 * k))}}) |
                              ((y_ext << (2 * k + 1)) & {64{1'(x >> (2 * k + 1))}})) & hi_mask);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/approx_mult_pipe_if.sv
// rtl/approx_mult_pipe_if.sv - operand/result handshake bundle for approx_mult_pipe
//
// Purpose : groups the operand input stream and the result output stream.
// Signals : in_valid/in_ready, x, y, mode (operand side)
//           out_valid/out_ready, z, z_err (result side)
// Modports: slave  - the multiplier (consumes operands, produces results)
//           master - the operand source / result sink
interface approx_mult_pipe_if
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic               mode;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] z;
    logic               z_err;

    modport slave (
        input  in_valid, x, y, mode, out_ready,
        output in_ready, out_valid, z, z_err
    );

    modport master (
        output in_valid, x, y, mode, out_ready,
        input  in_ready, out_valid, z, z_err
    );

endinterface

// File: rtl/approx_pp_compress.sv
// rtl/approx_pp_compress.sv - combinational exact/approximate product and error flag
//
// Purpose : computes exact P = x*y and approximate A, then selects by mode.
// Ports   : i_x, i_y  WIDTH operands
//           i_mode    0 = exact, 1 = approximate
//           o_z       2*WIDTH selected product
//           o_z_err   high when approximate mode and A != P
module approx_pp_compress
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int APPROX_ROWS = DEF_APPROX_ROWS
) (
    input  logic [WIDTH-1:0]   i_x,
    input  logic [WIDTH-1:0]   i_y,
    input  logic               i_mode,
    output logic [2*WIDTH-1:0] o_z,
    output logic               o_z_err
);

    localparam int PW = 2 * WIDTH;
    localparam int L  = APPROX_ROWS;

    // Columns below weight L are discarded in the approximated rows.
    localparam logic [PW-1:0] HI_MASK = ~((PW'(1) << L) - PW'(1));

    logic [PW-1:0] w_y_ext;
    logic [PW-1:0] w_exact;
    logic [PW-1:0] w_approx;

    assign w_y_ext = PW'(i_y);
    assign w_exact = PW'(i_x) * w_y_ext;

    // Upper rows multiply exactly; each low row pair becomes one OR-merged row.
    always_comb begin
        w_approx = (PW'(i_x >> L) * w_y_ext) << L;
        for (int k = 0; k < L / 2; k++) begin
            w_approx = w_approx +
                ((((w_y_ext << (2 * k))     & {PW{1'(i_x >> (2 * k))}}) |
                  ((w_y_ext << (2 * k + 1)) & {PW{1'(i_x >> (2 * k + 1))}})) & HI_MASK);
        end
    end

    assign o_z     = (i_mode == MODE_APPROX) ? w_approx : w_exact;
    assign o_z_err = (i_mode == MODE_APPROX) && (w_approx != w_exact);

endmodule

// File: rtl/approx_mult_pipe.sv
// rtl/approx_mult_pipe.sv - pipelined approximate multiplier with error-event counter
//
// Purpose : STAGES-deep valid/data pipeline around approx_pp_compress with
//           per-stage backpressure, plus a saturating count of delivered
//           results whose approximation changed the product.
// Ports   : clk, rst      clock, asynchronous active-high reset
//           bus (slave)   operand stream in, result stream out
//           cnt_clr       synchronous clear of err_count (wins over increment)
//           err_count     saturating CNT_W-bit error-event count
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int APPROX_ROWS = DEF_APPROX_ROWS,
    parameter int STAGES      = DEF_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    approx_mult_pipe_if.slave bus,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  err_count
);

    localparam int PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_err;
    logic [PW-1:0]     r_z [STAGES];
    logic [CNT_W-1:0]  r_cnt;

    logic [STAGES-1:0] w_load;
    logic              w_chain;
    logic [PW-1:0]     w_z0;
    logic              w_z_err0;
    logic              w_fire;

    approx_pp_compress #(
        .WIDTH       (WIDTH),
        .APPROX_ROWS (APPROX_ROWS)
    ) u_compress (
        .i_x     (bus.x),
        .i_y     (bus.y),
        .i_mode  (bus.mode),
        .o_z     (w_z0),
        .o_z_err (w_z_err0)
    );

    // A stage may load when it is empty or its contents move on this cycle;
    // the chain runs from out_ready back to in_ready so bubbles collapse.
    always_comb begin
        w_chain = bus.out_ready;
        w_load  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_chain   = !r_valid[k] | w_chain;
            w_load[k] = w_chain;
        end
    end

    assign bus.in_ready  = w_load[0];
    assign bus.out_valid = r_valid[STAGES-1];
    assign bus.z         = r_z[STAGES-1];
    assign bus.z_err     = r_err[STAGES-1];
    assign w_fire        = r_valid[STAGES-1] & bus.out_ready;
    assign err_count     = r_cnt;

    // Data registers only move with a valid entry, so a stalled or empty
    // stage keeps its last value instead of tracking the operand bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_err   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_z[k] <= '0;
            end
        end else begin
            if (w_load[0]) begin
                r_valid[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    r_z[0]   <= w_z0;
                    r_err[0] <= w_z_err0;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    if (r_valid[k-1]) begin
                        r_z[k]   <= r_z[k-1];
                        r_err[k] <= r_err[k-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_fire && r_err[STAGES-1] && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
